// File: rtl/seg_scan_if.sv
// Display-side bundle of the seven-segment scan controller.
// The master drives the requests and the slave returns the scan outputs.
interface seg_scan_if;
  logic        enable;
  logic        load;
  logic        lzb;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_done;

  modport master (
    output enable, load, lzb, value_in, dp_in,
    input  hex_out, an, dp, pending, frame_done
  );

  modport slave (
    input  enable, load, lzb, value_in, dp_in,
    output hex_out, an, dp, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// It applies guard time between digits, supports leading-zero blanking and double-buffers the data per frame.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 500,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_e;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - GUARD_CYC - 1);
  localparam logic [1:0]       IDX_LAST   = 2'(NUM_DIGITS - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [3:0]       act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       an_q, an_d, hex_q, hex_d;
  logic             dp_q, dp_d;
  logic             boundary;

  // A digit above 0 goes dark when it and every digit to its left hold zero.
  function automatic logic is_blanked(input logic [1:0] idx, input logic [15:0] val,
                                      input logic lzb);
    logic b;
    b = lzb && (idx != 2'd0);
    for (int k = 1; k < 4; k++) begin
      if (k >= int'(idx) && val[4*k +: 4] != 4'h0) b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        cnt_d = '0;
        if (bus.enable) begin
          state_d  = GUARD;
          boundary = 1'b1;
        end
      end
      GUARD: begin
        if (!bus.enable) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (!bus.enable) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == DRIVE_LAST) begin
          state_d  = GUARD;
          cnt_d    = '0;
          idx_d    = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
          boundary = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The frame-boundary transfer sees the pending buffer as it was before any coincident load.
    act_val_d    = (boundary && pending_q) ? pend_val_q : act_val_q;
    act_dp_d     = (boundary && pending_q) ? pend_dp_q  : act_dp_q;
    pend_val_d   = bus.load ? bus.value_in : pend_val_q;
    pend_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
    pending_d    = bus.load ? 1'b1 : (boundary ? 1'b0 : pending_q);
    frame_done_d = boundary;

    an_d  = 4'hF;
    dp_d  = 1'b1;
    hex_d = (state_d == IDLE) ? 4'h0 : act_val_d[{idx_d, 2'b00} +: 4];
    if (state_d == DRIVE && !is_blanked(idx_d, act_val_d, bus.lzb)) begin
      an_d = ~(4'b0001 << idx_d);
      dp_d = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'hF;
      dp_q         <= 1'b1;
      hex_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      hex_q        <= hex_d;
    end
  end

  assign bus.hex_out    = hex_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule
